// File: rtl/demux_deser8_pkg.sv
// demux_deser8 shared constants and types.
// Serial-to-parallel collector feeding the ALU operand registers.
package demux_deser8_pkg;

    localparam int DD_SEL_W     = 3;
    localparam int DD_WIDTH     = 1 << DD_SEL_W;
    localparam int DD_LSB_FIRST = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_STALL
    } state_e;

    // Slot written by the next accepted bit.
    function automatic logic [DD_SEL_W-1:0] slot_pos(
        input logic [DD_SEL_W-1:0] cnt,
        input logic                lsb_first
    );
        return lsb_first ? cnt : ~cnt;
    endfunction

endpackage

// File: rtl/demux_deser8_if.sv
// Serial-in / word-out handshake bundle for demux_deser8.
// master = source/consumer side, slave = collector.
interface demux_deser8_if;
    import demux_deser8_pkg::*;

    logic                clear;
    logic                in_bit;
    logic                in_valid;
    logic                in_ready;
    logic [DD_SEL_W-1:0] bit_idx;
    logic [DD_WIDTH-1:0] out_word;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output clear,
        output in_bit,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  bit_idx,
        input  out_word,
        input  out_valid
    );

    modport slave (
        input  clear,
        input  in_bit,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output bit_idx,
        output out_word,
        output out_valid
    );

endinterface

// File: rtl/demux_deser8_demux18.sv
// Combinational 1:8 decoder producing per-bit write enables.
// Output is all-zero when not enabled.
module demux18
    import demux_deser8_pkg::*;
(
    input  logic                i_en,
    input  logic [DD_SEL_W-1:0] i_sel,
    output logic [DD_WIDTH-1:0] o_we
);

    always_comb begin
        o_we = '0;
        if (i_en) begin
            o_we[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_deser8.sv
// Bit-serial collector: steers each bit into an assembly register
// and hands finished words off through a one-word output buffer.
module demux_deser8
    import demux_deser8_pkg::*;
#(
    parameter int WIDTH     = DD_WIDTH,
    parameter int SEL_W     = DD_SEL_W,
    parameter int LSB_FIRST = DD_LSB_FIRST
) (
    input  logic          clk,
    input  logic          rst,
    demux_deser8_if.slave bus
);

    localparam logic [SEL_W-1:0] LAST = '1;

    logic [SEL_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_asm;
    logic [WIDTH-1:0] r_word;
    logic             r_valid;

    state_e           w_state;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_done;
    logic [SEL_W-1:0] w_pos;
    logic [WIDTH-1:0] w_we;
    logic [WIDTH-1:0] w_word;

    // Only the 8th bit can stall: asm is separate from the out buffer.
    always_comb begin
        w_state = ST_IDLE;
        if (r_cnt == LAST && r_valid && !bus.out_ready) begin
            w_state = ST_STALL;
        end else if (r_cnt != '0) begin
            w_state = ST_COLLECT;
        end
    end

    always_comb begin
        w_in_ready = (w_state != ST_STALL);
        w_accept   = bus.in_valid & w_in_ready & ~bus.clear;
        w_done     = w_accept & (r_cnt == LAST);
        w_pos      = slot_pos(r_cnt, LSB_FIRST != 0);
    end

    demux18 u_demux (
        .i_en  (w_accept),
        .i_sel (w_pos),
        .o_we  (w_we)
    );

    // Completed word bypasses asm so it lands in the buffer directly.
    always_comb begin
        w_word = (r_asm & ~w_we) | ({WIDTH{bus.in_bit}} & w_we);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_asm <= '0;
        end else if (bus.clear) begin
            r_cnt <= '0;
            r_asm <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + SEL_W'(1);
            r_asm <= w_done ? '0 : w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word  <= '0;
            r_valid <= 1'b0;
        end else if (w_done) begin
            r_word  <= w_word;
            r_valid <= 1'b1;
        end else if (r_valid && bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.bit_idx   = r_cnt;
    assign bus.out_word  = r_word;
    assign bus.out_valid = r_valid;

endmodule

// File: tb/tb_demux_deser8.sv
// Directed table-driven bench for demux_deser8.
// Runs an LSB-first and an MSB-first instance side by side.
module tb_demux_deser8;

    typedef struct {
        logic       rst;
        logic       clr;
        logic       bit_;
        logic       vld;
        logic       ordy;
        logic [2:0] idx;
        logic       irdy;
        logic       ovld;
        logic [7:0] word;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst, clr, bit_, vld, ordy;
    int   total = 0;
    int   bad   = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    demux_deser8_if if_l ();
    demux_deser8_if if_m ();

    assign if_l.clear     = clr;
    assign if_l.in_bit    = bit_;
    assign if_l.in_valid  = vld;
    assign if_l.out_ready = ordy;
    assign if_m.clear     = clr;
    assign if_m.in_bit    = bit_;
    assign if_m.in_valid  = vld;
    assign if_m.out_ready = ordy;

    demux_deser8 #(.LSB_FIRST(1)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (if_l.slave)
    );

    demux_deser8 #(.LSB_FIRST(0)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (if_m.slave)
    );

    function automatic logic [7:0] rev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input logic [2:0] idx,
                             input logic irdy, input logic ovld,
                             input logic [7:0] w);
        chk({nm, ".l.idx"}, 8'(if_l.bit_idx), 8'(idx));
        chk({nm, ".l.irdy"}, 8'(if_l.in_ready), 8'(irdy));
        chk({nm, ".l.ovld"}, 8'(if_l.out_valid), 8'(ovld));
        chk({nm, ".l.word"}, if_l.out_word, w);
        chk({nm, ".m.idx"}, 8'(if_m.bit_idx), 8'(idx));
        chk({nm, ".m.irdy"}, 8'(if_m.in_ready), 8'(irdy));
        chk({nm, ".m.ovld"}, 8'(if_m.out_valid), 8'(ovld));
        chk({nm, ".m.word"}, if_m.out_word, rev8(w));
    endtask

    task automatic drive(input logic r, input logic c, input logic b,
                         input logic v, input logic o);
        @(negedge clk);
        rst  = r;
        clr  = c;
        bit_ = b;
        vld  = v;
        ordy = o;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic c, input logic b,
                       input logic v, input logic o, input logic [2:0] idx,
                       input logic irdy, input logic ovld,
                       input logic [7:0] w, input string nm);
        vec_t e;
        e.rst  = r;
        e.clr  = c;
        e.bit_ = b;
        e.vld  = v;
        e.ordy = o;
        e.idx  = idx;
        e.irdy = irdy;
        e.ovld = ovld;
        e.word = w;
        e.name = nm;
        tbl.push_back(e);
    endtask

    // n back-to-back bits of d (bit 0 first) starting from bit_idx 0.
    task automatic add_stream(input logic [7:0] d, input int n,
                              input logic o, input logic [7:0] hw,
                              input logic hv, input string nm);
        logic [2:0] idx;
        logic       cv;
        logic [7:0] cw;
        for (int k = 0; k < n; k++) begin
            idx = 3'((k + 1) % 8);
            cv  = (k == 7) ? 1'b1 : hv;
            cw  = (k == 7) ? d : hw;
            add(0, 0, d[k], 1, o, idx,
                !(idx == 3'd7 && cv && !o), cv, cw,
                $sformatf("%s[%0d]", nm, k));
        end
    endtask

    initial begin
        logic [7:0] bb;
        bb = 8'h96;

        add_stream(8'h4D, 8, 1, 8'h00, 0, "s4d");
        add(0, 0, 0, 0, 1, 3'd0, 1, 0, 8'h4D, "s4d_once");

        add_stream(8'hA5, 8, 0, 8'h4D, 0, "bp_a5");
        add_stream(8'h3C, 7, 0, 8'hA5, 1, "bp_3c");
        add(0, 0, 0, 1, 0, 3'd7, 0, 1, 8'hA5, "stall0");
        add(0, 0, 0, 1, 0, 3'd7, 0, 1, 8'hA5, "stall1");
        add(0, 0, 0, 1, 1, 3'd0, 1, 1, 8'h3C, "bp_release");
        add(0, 0, 1, 0, 1, 3'd0, 1, 0, 8'h3C, "bp_drain");

        for (int k = 0; k < 8; k++) begin
            add(0, 0, bb[k], 1, 1, 3'((k + 1) % 8), 1, (k == 7),
                (k == 7) ? 8'h96 : 8'h3C, $sformatf("bub_bit%0d", k));
            add(0, 0, ~bb[k], 0, 1, 3'((k + 1) % 8), 1, 0,
                (k == 7) ? 8'h96 : 8'h3C, $sformatf("bub_gap%0d", k));
        end

        add_stream(8'h5A, 8, 0, 8'h96, 0, "hold_5a");
        add_stream(8'h07, 3, 0, 8'h5A, 1, "partial");
        add(0, 1, 1, 1, 0, 3'd0, 1, 1, 8'h5A, "clear");
        add(0, 0, 0, 0, 1, 3'd0, 1, 0, 8'h5A, "take_5a");
        add_stream(8'hF0, 8, 1, 8'h5A, 0, "f0");
        add(0, 0, 0, 0, 1, 3'd0, 1, 0, 8'hF0, "f0_take");

        rst  = 1'b1;
        clr  = 1'b0;
        bit_ = 1'b1;
        vld  = 1'b1;
        ordy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 3'd0, 1, 0, 8'h00);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].clr, tbl[i].bit_, tbl[i].vld,
                  tbl[i].ordy);
            check_all(tbl[i].name, tbl[i].idx, tbl[i].irdy,
                      tbl[i].ovld, tbl[i].word);
        end

        bb = 8'hC3;
        for (int k = 0; k < 8; k++) drive(0, 0, bb[k], 1, 0);
        for (int k = 0; k < 7; k++) drive(0, 0, 1'b1, 1, 0);
        check_all("pre_rst_stall", 3'd7, 0, 1, 8'hC3);
        drive(1, 0, 1'b1, 1, 0);
        check_all("rst_in_stall", 3'd0, 1, 0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_deser8.md
Name: demux_deser8

Overview:
- Serial-to-parallel collector: the write-side counterpart of the ALU's 8:1 bit-select mux.
- A 3-bit bit index steers each incoming serial bit into one slot of an 8-bit assembly register; this is a 1:8 demux driven by a counter.
- Completed words are handed off through a one-word output buffer with valid/ready handshake.
- Sits between a bit-serial source (shift/test path) and the ALU operand registers.

Parameters:
- WIDTH, 8, output word width; fixed to 2**SEL_W.
- SEL_W, 3, bit-index width.
- LSB_FIRST, 1, 1 = first bit lands in bit 0; 0 = first bit lands in bit WIDTH-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous abort of the partial word.
- in_bit  input  1  serial data bit.
- in_valid  input  1  in_bit is valid this cycle.
- in_ready  output  1  block accepts in_bit this cycle.
- bit_idx  output  SEL_W  current demux select (count of bits accepted in the current word).
- out_word  output  WIDTH  assembled word.
- out_valid  output  1  out_word holds an unconsumed word.
- out_ready  input  1  consumer takes out_word this cycle.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: asm=0, cnt=0, out_word=0, out_valid=0. Consequently bit_idx=0 and in_ready=1.
- State machine, a view of cnt and out_valid:
  - IDLE: cnt=0.
  - COLLECT: cnt 1..7.
  - STALL: cnt=7 and out_valid and !out_ready.
- in_ready = (cnt != 7) | !out_valid | out_ready.
  - Bits 0..6 are always accepted, because the assembly register is separate from the output buffer.
  - Only the 8th bit can stall.
- Accept: when in_valid & in_ready.
  - Write slot pos = LSB_FIRST ? cnt : 7-cnt, i.e. asm[pos] <= in_bit. The other asm bits hold.
  - cnt <= cnt+1, wrapping 7 -> 0.
- Word completion, on the accept with cnt==7:
  - out_word <= asm with slot pos replaced by in_bit. The completed word bypasses asm, so there are zero extra cycles.
  - out_valid <= 1, visible the cycle after the 8th accept edge.
  - asm <= 0.
- Output handshake:
  - out_valid & out_ready with no completion the same cycle: out_valid <= 0; out_word holds its last value.
  - Simultaneous consume and completion: out_valid stays 1 and out_word takes the new word.
  - out_word is stable while out_valid & !out_ready.
- in_valid low: nothing advances, and bubbles are allowed anywhere in a word.
- clear: cnt <= 0, asm <= 0.
  - An accept in the same cycle is discarded.
  - out_word and out_valid are unaffected, so a held word survives.
- Precedence: rst > clear > accept.
- rst mid-word or during STALL: everything returns to reset values next cycle, and the held word is lost.
- Width rule: cnt is SEL_W bits and wraps naturally. No overrun is possible, because the 8th bit stalls rather than overwriting.

Decomposition:
- Shared package or include file: SEL_W, WIDTH, and the LSB_FIRST default as constants.
- Sub-module demux18 (combinational 1:8 decoder):
  - Inputs: en, sel[2:0].
  - Output: one-hot we[7:0].
  - The top level instantiates it with en = accept, and uses we as per-bit write enables for asm.
  - The completion word is formed as (asm & ~we) | ({8{in_bit}} & we).

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_word=8'h00, bit_idx=0, in_ready=1; no bit is captured.
- LSB_FIRST=1, out_ready=1: stream 1,0,1,1,0,0,1,0 back-to-back -> out_word=8'h4D with out_valid high for exactly 1 cycle, the cycle after the 8th accept. Same stream with LSB_FIRST=0 -> 8'hB2.
- Backpressure, out_ready=0: send 8'hA5 then the bits of 8'h3C.
  - out_word holds 8'hA5.
  - After 7 bits, bit_idx=7 and in_ready=0 with in_valid held.
  - Raise out_ready: the 8'hA5 handshake and the 8th accept happen on the same edge. Next cycle out_word=8'h3C, out_valid=1 with no gap.
- Bubbles: 8'h96 sent with in_valid low on alternate cycles -> out_word=8'h96; bit_idx advances only on accepts.
- clear after 3 bits of a word while 8'h5A is held unconsumed -> bit_idx=0, out_word=8'h5A unchanged. A following 8'hF0 assembles with no residue from the aborted bits.
- rst asserted in STALL, with bit_idx=7 and out_valid=1 -> next cycle out_valid=0, out_word=0, bit_idx=0, in_ready=1.
